// File: rtl/pixel_out_serializer_pkg.sv
// pixel_out_serializer_pkg
//   Constants and helpers shared by the pixel output path and the upstream
//   buffer stage: component width, components per pixel, pixels per word,
//   the packed word/pixel types and a pixel slice helper.
//   Packing: a word is {p3,p2,p1,p0}, each pixel is {c2,c1,c0}, each
//   component COMP_W bits wide.
package pixel_out_serializer_pkg;

   localparam int COMP_W        = 14;
   localparam int COMP_PER_PIX  = 3;
   localparam int PIX_PER_WORD  = 4;
   localparam int PIX_W         = COMP_W * COMP_PER_PIX;
   localparam int WORD_W        = PIX_W * PIX_PER_WORD;
   localparam int COMP_PER_WORD = COMP_PER_PIX * PIX_PER_WORD;

   typedef logic [COMP_W-1:0] comp_t;
   typedef logic [PIX_W-1:0]  pixel_t;
   typedef logic [WORD_W-1:0] word_t;

   // One FIFO entry: clipped word plus its start-of-frame tag.
   typedef struct packed {
      logic  sof;
      word_t data;
   } fifo_entry_t;

   // Pixel idx (0 = least significant) of a packed word.
   function automatic pixel_t get_pixel(input word_t word, input int idx);
      return word[idx*PIX_W +: PIX_W];
   endfunction

   // Component idx (0 = p0c0) of a packed word.
   function automatic comp_t get_comp(input word_t word, input int idx);
      return word[idx*COMP_W +: COMP_W];
   endfunction

endpackage

// File: rtl/pixel_out_serializer_if.sv
// pixel_out_serializer_word_if
//   Input word bus from the decoder output buffers. No backpressure: a word
//   is presented for exactly the cycles in_valid is high.
//     in_valid  : word strobe
//     in_sof    : first word of a frame (qualified by in_valid)
//     in_data_p : {p3c2..p0c0}, signed components
//
// pixel_out_serializer_stream_if
//   Output pixel stream, PPC pixels per beat.
//   Handshake: a beat transfers on a rising edge where out_valid and
//   out_ready are both high. Once out_valid is high, out_valid, out_data_p,
//   out_sof and out_eol stay unchanged until that transfer; out_valid never
//   depends on out_ready combinationally.
//     out_valid/out_ready : handshake
//     out_data_p          : {pNc2..p0c0}, unsigned
//     out_sof             : first beat of a frame
//     out_eol             : last beat of a line
interface pixel_out_serializer_word_if;
   import pixel_out_serializer_pkg::*;

   logic  in_valid;
   logic  in_sof;
   word_t in_data_p;

   modport master (output in_valid, in_sof, in_data_p);
   modport slave  (input  in_valid, in_sof, in_data_p);
endinterface

interface pixel_out_serializer_stream_if #(
   parameter int PPC = 1
);
   import pixel_out_serializer_pkg::*;

   logic                 out_valid;
   logic                 out_ready;
   logic [PPC*PIX_W-1:0] out_data_p;
   logic                 out_sof;
   logic                 out_eol;

   modport master (output out_valid, out_data_p, out_sof, out_eol, input out_ready);
   modport slave  (input  out_valid, out_data_p, out_sof, out_eol, output out_ready);
endinterface

// File: rtl/pixel_out_serializer_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with registered read/write pointers carrying an extra
//   wrap bit; full and empty are decoded combinationally from the pointers.
//   Read data is the head entry, valid whenever o_empty is low.
//   A write while full is accepted only if a read happens in the same cycle.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     i_clr               : synchronous clear of both pointers
//     i_wr_en, i_wr_data  : write request and data
//     i_rd_en             : pop the head entry
//     o_rd_data           : head entry
//     o_full, o_empty     : status
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_wr;
   logic             w_do_rd;

   // Same address with opposite wrap bits means the writer lapped the reader.
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_empty = (r_wr_ptr == r_rd_ptr);

   assign w_do_rd   = i_rd_en & ~o_empty;
   assign w_do_wr   = i_wr_en & (~o_full | w_do_rd);
   assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_do_wr && !i_clr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

endmodule

// File: rtl/pixel_out_serializer.sv
// pixel_out_serializer
//   Clips each component of incoming 4-pixel words to bits_per_component,
//   queues the words (with their sof tag) in a FIFO and serializes them as
//   PPC pixels per beat on a valid/ready stream with sof/eol tags. Words
//   arriving while the FIFO is full (and not popping) are dropped and flag a
//   sticky overflow.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     sof                 : synchronous frame restart (clears FIFO, counters,
//                           out_valid, overflow; drops a same-cycle word)
//     slice_width         : pixels per line (multiple of 4)
//     bits_per_component  : output bit depth 8..14
//     in_if               : input word bus (slave)
//     out_if              : output pixel stream (master)
//     overflow            : sticky word-dropped flag
module pixel_out_serializer
   import pixel_out_serializer_pkg::*;
#(
   parameter int MAX_SLICE_WIDTH = 2560,
   parameter int PPC             = 1,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               sof,
   input  logic [$clog2(MAX_SLICE_WIDTH)-1:0] slice_width,
   input  logic [3:0]                         bits_per_component,
   pixel_out_serializer_word_if.slave         in_if,
   pixel_out_serializer_stream_if.master      out_if,
   output logic                               overflow
);

   localparam int SW_W    = $clog2(MAX_SLICE_WIDTH);
   localparam int NPHASE  = PIX_PER_WORD / PPC;
   localparam int PH_W    = (NPHASE > 1) ? $clog2(NPHASE) : 1;
   localparam int ENTRY_W = $bits(fifo_entry_t);
   localparam int BEAT_W  = PPC * PIX_W;

   // ---------------- clip on write ----------------
   logic [COMP_W:0] w_max;
   word_t           w_clip_data;

   assign w_max = (15'd1 << bits_per_component) - 15'd1;

   for (genvar g = 0; g < COMP_PER_WORD; g++) begin : g_clip
      comp_t w_comp;
      assign w_comp = get_comp(in_if.in_data_p, g);
      // MSB set means negative; otherwise compare as unsigned against the max.
      assign w_clip_data[g*COMP_W +: COMP_W] =
         w_comp[COMP_W-1]        ? '0 :
         ({1'b0, w_comp} > w_max) ? w_max[COMP_W-1:0] : w_comp;
   end

   // ---------------- FIFO ----------------
   fifo_entry_t        w_wr_entry;
   fifo_entry_t        w_head;
   logic [ENTRY_W-1:0] w_head_raw;
   logic               w_wr_en;
   logic               w_full;
   logic               w_empty;
   logic               w_pop;

   assign w_wr_entry.sof  = in_if.in_sof;
   assign w_wr_entry.data = w_clip_data;
   assign w_wr_en         = in_if.in_valid & ~sof;
   assign w_head          = fifo_entry_t'(w_head_raw);

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (sof),
      .i_wr_en   (w_wr_en),
      .i_wr_data (w_wr_entry),
      .i_rd_en   (w_pop),
      .o_rd_data (w_head_raw),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   // ---------------- beat formation ----------------
   logic              r_out_valid;
   logic [BEAT_W-1:0] r_out_data;
   logic              r_out_sof;
   logic              r_out_eol;
   logic              r_overflow;
   logic [PH_W-1:0]   r_phase;
   logic [SW_W-1:0]   r_x;

   logic              w_load;
   logic              w_last_phase;
   logic              w_beat_sof;
   logic              w_eol;
   logic              w_drop;
   logic [SW_W-1:0]   w_x_cur;
   logic [BEAT_W-1:0] w_beat;

   assign w_last_phase = (r_phase == PH_W'(NPHASE - 1));
   // The output register takes a new beat when it is empty or being drained.
   assign w_load       = ~w_empty & (~r_out_valid | out_if.out_ready) & ~sof;
   // The head word is consumed as its last beat moves into the output register.
   assign w_pop        = w_load & w_last_phase;
   assign w_beat_sof   = w_head.sof & (r_phase == '0);
   // A tagged word starts a new line regardless of where x was.
   assign w_x_cur      = w_beat_sof ? '0 : r_x;
   assign w_eol        = (w_x_cur == slice_width - SW_W'(PPC));
   assign w_drop       = w_wr_en & w_full & ~w_pop;

   always_comb begin
      w_beat = '0;
      for (int p = 0; p < PPC; p++) begin
         w_beat[p*PIX_W +: PIX_W] = get_pixel(w_head.data, int'(r_phase) * PPC + p);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sof   <= 1'b0;
         r_out_eol   <= 1'b0;
         r_overflow  <= 1'b0;
         r_phase     <= '0;
         r_x         <= '0;
      end else if (sof) begin
         r_out_valid <= 1'b0;
         r_out_sof   <= 1'b0;
         r_out_eol   <= 1'b0;
         r_overflow  <= 1'b0;
         r_phase     <= '0;
         r_x         <= '0;
      end else begin
         if (w_drop) r_overflow <= 1'b1;
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_beat;
            r_out_sof   <= w_beat_sof;
            r_out_eol   <= w_eol;
            r_phase     <= w_last_phase ? '0 : r_phase + PH_W'(1);
            r_x         <= w_eol ? '0 : w_x_cur + SW_W'(PPC);
         end else if (out_if.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_if.out_valid  = r_out_valid;
   assign out_if.out_data_p = r_out_data;
   assign out_if.out_sof    = r_out_sof;
   assign out_if.out_eol    = r_out_eol;
   assign overflow          = r_overflow;

endmodule

// File: doc/pixel_out_serializer.md
# pixel_out_serializer

Downstream neighbour of the decoder output buffers. Accepts 4-pixel × 3-component words (14-bit signed components) with no upstream backpressure, clips each component to the configured bit depth, and buffers words in a small FIFO. Serializes them onto a PPC-pixel-per-beat valid/ready stream with start-of-frame and end-of-line tags, and flags any overflow caused by sink stalls.

## Interface
Parameters:
- MAX_SLICE_WIDTH, 2560, maximum pixels per line; sizes the x counter.
- PPC, 1, output pixels per beat; legal values 1, 2, 4.
- FIFO_DEPTH, 16, input word FIFO entries (power of 2, ≥4).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- sof  in  1  synchronous frame restart; clears FIFO, counters, overflow.
- slice_width  in  $clog2(MAX_SLICE_WIDTH)  pixels per line; multiple of 4; static between sof pulses.
- bits_per_component  in  4  output bit depth, 8..14.
- in_valid  in  1  input word strobe.
- in_sof  in  1  tags first word of a frame; qualified by in_valid.
- in_data_p  in  4*3*14  {p3c2,p3c1,p3c0,…,p0c2,p0c1,p0c0}, signed components.
- out_ready  in  1  sink ready.
- out_valid  out  1  beat valid.
- out_data_p  out  PPC*3*14  {pNc2,pNc1,pNc0,…,p0c0}; unsigned, upper (14-bpc) bits zero.
- out_sof  out  1  first beat of frame.
- out_eol  out  1  last beat of a line.
- overflow  out  1  sticky: a word was dropped.

## Operation
- Clip on write: each component c → 0 if c<0; (1<<bpc)-1 if c>(1<<bpc)-1; else c. The in_sof bit is stored alongside as a tag.
- FIFO write when in_valid. If full and no pop in the same cycle, drop the word and set overflow. If full with a simultaneous pop, accept the write.
- Phase counter 0..(4/PPC-1) selects pixels [phase*PPC +: PPC] of the head word. Pop the head word when a beat completes on its last phase.
- Output register loads when out_valid==0 or out_ready==1, and head data exists. Otherwise it holds; out_data_p, out_sof, and out_eol stay stable while out_valid & ~out_ready.
- out_sof = head word's sof tag & phase==0. A tagged word also resets the x counter to 0.
- x counter advances by PPC per accepted beat. out_eol = (x == slice_width-PPC); then x wraps to 0.
- sof: FIFO pointers, phase, x, out_valid, and overflow all clear next cycle. Any in_valid in the same cycle as sof is discarded.
- Reset values: out_valid=0, out_sof=0, out_eol=0, overflow=0, out_data_p=0. FIFO empty, phase=0, x=0.
- Asserting rst_n low mid-frame aborts immediately. There is no partial-beat drain.

## Timing
- Latency: word written at edge N (FIFO empty, output idle) → out_valid high after edge N+1.
- Sustained throughput: 1 beat/clk. Input rate must average ≤ 1 word per 4/PPC clocks; bursts absorbed up to FIFO_DEPTH.
- Full flag is combinational from registered pointers (wrap bit + address). Empty likewise.
- overflow sets the edge after the dropped write and holds until sof or reset.
- bits_per_component and slice_width are sampled continuously and must be static from sof to end of frame.

## Structure
- Shared package: component width (14), components per pixel (3), pixels per input word (4), and the packed-pixel slice helpers. The upstream buffer stage uses the same constants.
- Sub-module: sync_fifo (parameterized width/depth, wrap-bit full/empty, registered pointers). Reuse it in other stages.
- Clip logic stays inline as a generate loop over 12 components.

## Test plan
- PPC=1, bpc=10, slice_width=8: two words pixel k = {k,k,k}, out_ready=1 → 8 beats 0..7 one per clk; out_sof on beat 0, out_eol on beat 7, first out_valid 2 clks after first in_valid.
- Clip: bpc=8, components −5, 300, 255, 0 → 0, 255, 255, 0; bpc=14, 8191 → 8191.
- Backpressure: PPC=2, out_ready toggled 1/0 each clk → no duplicated or lost pixels; data, out_sof, and out_eol stable while stalled.
- Overflow: FIFO_DEPTH=16, out_ready=0, 17 words → 17th dropped, overflow=1 next clk; sof clears overflow and out_valid.
- Full with simultaneous pop: FIFO full, out_ready=1 on the last-phase beat, new word in the same clk → accepted, overflow stays 0.
- Reset mid-frame: rst_n low during an active beat → all outputs 0 immediately; after release, a new in_sof frame starts cleanly at x=0.
